// File: rtl/heat_actuator_ctrl.sv
// heat_actuator_ctrl
//
// Purpose: drives the heater and circulation fan from the selected heating
// mode (eco/comfort). It provides a thermostat with hysteresis, fan pre-run
// before the heater and fan post-run after it, and min-on/min-off timers
// that prevent short cycling.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   enable            heating system enabled
//   selected_mode     requested mode (0=eco, 1=comfort)
//   mode_valid/ready  mode update handshake
//   temp_in           measured room temperature (unsigned, TEMP_W bits)
//   setpoint_eco      eco target
//   setpoint_comfort  comfort target
//   heater_on         heater drive (HEAT only)
//   fan_on            fan drive (PREHEAT, HEAT, COOLDOWN)
//   state             FSM state code (debug/observation)
//   fault             sticky over-temperature flag
//
// Optional feature: define HEAT_OVERTEMP_PROT_EN to enable over-temperature
// protection against MAX_TEMP. Without it, fault is tied to 0.
//
// Handshake: a mode update transfers on any clock edge where
// mode_valid && mode_ready. The new mode takes effect from the next cycle.
// A mode_valid seen while mode_ready=0 is dropped and is not held for later.

module heat_actuator_ctrl #(
    parameter int unsigned        TEMP_W         = 8,
    parameter int unsigned        HYST           = 2,
    parameter int unsigned        PREHEAT_CYCLES = 8,
    parameter int unsigned        MIN_ON_CYCLES  = 16,
    parameter int unsigned        COOL_CYCLES    = 8,
    parameter int unsigned        MIN_OFF_CYCLES = 16,
    parameter logic [TEMP_W-1:0]  MAX_TEMP       = 8'd90
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              selected_mode,
    input  logic              mode_valid,
    output logic              mode_ready,
    input  logic [TEMP_W-1:0] temp_in,
    input  logic [TEMP_W-1:0] setpoint_eco,
    input  logic [TEMP_W-1:0] setpoint_comfort,
    output logic              heater_on,
    output logic              fan_on,
    output logic [2:0]        state,
    output logic              fault
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_IDLE     = 3'd1,
        S_PREHEAT  = 3'd2,
        S_HEAT     = 3'd3,
        S_COOLDOWN = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_e;

    localparam int unsigned MAX_A = (PREHEAT_CYCLES > MIN_ON_CYCLES) ? PREHEAT_CYCLES : MIN_ON_CYCLES;
    localparam int unsigned MAX_B = (COOL_CYCLES > MIN_OFF_CYCLES) ? COOL_CYCLES : MIN_OFF_CYCLES;
    localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W = $clog2(MAX_T) + 1;
    localparam int unsigned EXT_W = TEMP_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREHEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_CYCLES - 1);
    localparam logic [EXT_W-1:0] HYST_X    = EXT_W'(HYST);
    localparam logic [EXT_W-1:0] TEMP_TOP  = {1'b0, {TEMP_W{1'b1}}};

    state_e           state_q;
    logic [CNT_W-1:0] cnt;
    logic             active_mode;
    logic             fault_q;

    // Thresholds are computed one bit wider so that target+HYST cannot wrap.
    logic [TEMP_W-1:0] target;
    logic [EXT_W-1:0]  target_x;
    logic [EXT_W-1:0]  temp_x;
    logic [EXT_W-1:0]  hi_sum;
    logic [EXT_W-1:0]  lo_th;
    logic [EXT_W-1:0]  hi_th;
    logic              demand;
    logic              satisfied;
    logic              overtemp;

    assign target    = active_mode ? setpoint_comfort : setpoint_eco;
    assign target_x  = {1'b0, target};
    assign temp_x    = {1'b0, temp_in};
    assign hi_sum    = target_x + HYST_X;
    assign lo_th     = (target_x >= HYST_X) ? (target_x - HYST_X) : '0;
    assign hi_th     = (hi_sum > TEMP_TOP) ? TEMP_TOP : hi_sum;
    assign demand    = temp_x < lo_th;
    assign satisfied = temp_x >= hi_th;

`ifdef HEAT_OVERTEMP_PROT_EN
    assign overtemp = temp_in >= MAX_TEMP;
`else
    // Without protection MAX_TEMP has no effect. It is folded into a sink so
    // that the parameter set is the same in both builds.
    logic unused_max_temp;
    assign unused_max_temp = ^MAX_TEMP;
    assign overtemp = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OFF;
            cnt         <= '0;
            active_mode <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            if (mode_valid && mode_ready)
                active_mode <= selected_mode;

            // The dwell counter saturates. Each transition below clears it,
            // so it always holds the number of cycles spent in the state.
            if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (state_q == S_OFF && !enable)
                fault_q <= 1'b0;

            case (state_q)
                S_OFF: begin
                    if (enable) begin
                        state_q <= S_IDLE;
                        cnt     <= '0;
                    end
                end
                S_IDLE: begin
                    if (!enable) begin
                        state_q <= S_OFF;
                        cnt     <= '0;
                    end else if (demand && !fault_q) begin
                        state_q <= S_PREHEAT;
                        cnt     <= '0;
                    end
                end
                S_PREHEAT: begin
                    // Over-temperature wins so that the fan still post-runs.
                    if (overtemp) begin
                        state_q <= S_COOLDOWN;
                        cnt     <= '0;
                        fault_q <= 1'b1;
                    end else if (!enable) begin
                        state_q <= S_OFF;
                        cnt     <= '0;
                    end else if (cnt == PRE_LAST) begin
                        state_q <= S_HEAT;
                        cnt     <= '0;
                    end
                end
                S_HEAT: begin
                    if (overtemp) begin
                        state_q <= S_COOLDOWN;
                        cnt     <= '0;
                        fault_q <= 1'b1;
                    end else if (!enable || (cnt >= ON_LAST && satisfied)) begin
                        state_q <= S_COOLDOWN;
                        cnt     <= '0;
                    end
                end
                S_COOLDOWN: begin
                    if (cnt == COOL_LAST) begin
                        state_q <= S_LOCKOUT;
                        cnt     <= '0;
                    end
                end
                S_LOCKOUT: begin
                    if (cnt == OFF_LAST) begin
                        state_q <= enable ? S_IDLE : S_OFF;
                        cnt     <= '0;
                    end
                end
                default: begin
                    state_q <= S_OFF;
                    cnt     <= '0;
                end
            endcase
        end
    end

    // Moore decodes of the state register.
    assign state      = state_q;
    assign heater_on  = (state_q == S_HEAT);
    assign fan_on     = (state_q == S_PREHEAT) || (state_q == S_HEAT) || (state_q == S_COOLDOWN);
    assign mode_ready = (state_q == S_OFF) || (state_q == S_IDLE) ||
                        (state_q == S_HEAT) || (state_q == S_LOCKOUT);
    assign fault      = fault_q;

endmodule
